// File: rtl/icache_burst_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_burst_mem_responder_pkg
// Description : Shared line geometry and responder state encodings for the
//               cache refill memory responders.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_burst_mem_responder_pkg;

    localparam int LINE_BEATS        = 8;
    localparam int LINE_OFFSET_WIDTH = 5;
    localparam int BEAT_WIDTH        = 3;
    localparam int STATE_WIDTH       = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 3'b001,
        ST_LAT   = 3'b010,
        ST_BURST = 3'b100
    } rsp_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_burst_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : burst_word_ram
// Description : Word-wide instruction RAM, one synchronous write port and one
//               asynchronous read port. Contents survive reset.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_word_ram #(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/icache_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : icache_burst_mem_responder
// Description : Accepts one line refill at a time and streams it back as an
//               8-beat burst from a preloadable instruction RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_burst_mem_responder
    import icache_burst_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS   = 4096,
    parameter int RSP_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cache_rd_req_valid,
    input  logic [31:0] from_cache_rd_req_addr,
    output logic        to_cache_rd_req_ready,
    output logic        to_cache_rd_rsp_valid,
    output logic [31:0] to_cache_rd_rsp_data,
    output logic        to_cache_rd_rsp_last,
    input  logic        from_cache_rd_rsp_ready,
    input  logic        preload_wen,
    input  logic [31:0] preload_addr,
    input  logic [31:0] preload_wdata
);

    localparam int         c_addr_width = $clog2(MEM_WORDS);
    localparam int         c_base_width = 32 - LINE_OFFSET_WIDTH;
    localparam logic [3:0] c_latency    = 4'(RSP_LATENCY);

    rsp_state_t                          r_state;
    rsp_state_t                          w_next_state;
    logic [c_base_width-1:0]             r_line_base;
    logic [BEAT_WIDTH-1:0]               r_beat;
    logic [3:0]                          r_lat_cnt;
    logic                                w_accept;
    logic                                w_beat_hs;
    logic                                w_in_burst;
    logic [c_base_width+BEAT_WIDTH-1:0]  w_word_index;
    logic [c_addr_width-1:0]             w_rd_addr;
    logic [c_addr_width-1:0]             w_wr_addr;
    logic [31:0]                         w_ram_rdata;
    logic                                w_unused_addr_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_beat_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (from_cache_rd_req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (RSP_LATENCY == 0) ? ST_BURST : ST_LAT;
                end
            end
            ST_LAT: begin
                if (r_lat_cnt <= 4'd1) begin
                    w_next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                if (from_cache_rd_rsp_ready) begin
                    w_beat_hs = 1'b1;
                    if (r_beat == BEAT_WIDTH'(LINE_BEATS - 1)) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_base <= '0;
            r_beat      <= '0;
            r_lat_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_line_base <= from_cache_rd_req_addr[31:LINE_OFFSET_WIDTH];
                r_beat      <= '0;
                r_lat_cnt   <= c_latency;
            end else if (r_state == ST_LAT) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (w_beat_hs) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Ready is masked by rst so it reads 0 for the whole reset pulse.
    assign w_in_burst            = (r_state == ST_BURST);
    assign to_cache_rd_req_ready = (r_state == ST_IDLE) && !rst;
    assign to_cache_rd_rsp_valid = w_in_burst;
    assign to_cache_rd_rsp_last  = w_in_burst && (r_beat == BEAT_WIDTH'(LINE_BEATS - 1));
    assign to_cache_rd_rsp_data  = w_in_burst ? w_ram_rdata : 32'h0;

    // Word index wraps modulo the RAM depth, so out-of-range lines alias.
    assign w_word_index = {r_line_base, r_beat};
    assign w_rd_addr    = w_word_index[c_addr_width-1:0];
    assign w_wr_addr    = preload_addr[c_addr_width+1:2];

    assign w_unused_addr_bits = ^{preload_addr, w_word_index,
                                  from_cache_rd_req_addr[LINE_OFFSET_WIDTH-1:0]};

    burst_word_ram #(
        .DEPTH      (MEM_WORDS),
        .ADDR_WIDTH (c_addr_width)
    ) u_ram (
        .clk     (clk),
        .i_we    (preload_wen),
        .i_waddr (w_wr_addr),
        .i_wdata (preload_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_icache_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_burst_mem_responder
// Description : Self-checking bench for the refill responder; two instances
//               (latency 2 and latency 0) share the preload bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_burst_mem_responder;

    localparam int MEM  = 4096;
    localparam int LAT0 = 2;
    localparam int LAT1 = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_last;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] req_addr [2];
    logic [31:0] rsp_data [2];
    logic        preload_wen   = 1'b0;
    logic [31:0] preload_addr  = 32'h0;
    logic [31:0] preload_wdata = 32'h0;

    always #5 clk = ~clk;

    icache_burst_mem_responder #(.MEM_WORDS(MEM), .RSP_LATENCY(LAT0)) u_dut (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid[0]), .from_cache_rd_req_addr(req_addr[0]),
        .to_cache_rd_req_ready(req_ready[0]), .to_cache_rd_rsp_valid(rsp_valid[0]),
        .to_cache_rd_rsp_data(rsp_data[0]), .to_cache_rd_rsp_last(rsp_last[0]),
        .from_cache_rd_rsp_ready(rsp_ready[0]),
        .preload_wen(preload_wen), .preload_addr(preload_addr), .preload_wdata(preload_wdata)
    );

    icache_burst_mem_responder #(.MEM_WORDS(MEM), .RSP_LATENCY(LAT1)) u_dut_lat0 (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid[1]), .from_cache_rd_req_addr(req_addr[1]),
        .to_cache_rd_req_ready(req_ready[1]), .to_cache_rd_rsp_valid(rsp_valid[1]),
        .to_cache_rd_rsp_data(rsp_data[1]), .to_cache_rd_rsp_last(rsp_last[1]),
        .from_cache_rd_rsp_ready(rsp_ready[1]),
        .preload_wen(preload_wen), .preload_addr(preload_addr), .preload_wdata(preload_wdata)
    );

    // ------------------------------------------------------------------
    // Reference model: a line request occupies the port from the accept
    // edge until beat 7 is taken; beats show from RSP_LATENCY edges later.
    // ------------------------------------------------------------------
    int          total  = 0;
    int          passed = 0;
    longint      cyc    = 0;
    logic [31:0] model_ram [MEM];
    bit          busy  [2];
    int          since [2];
    int          beats [2];
    logic [26:0] base  [2];
    int          lat   [2];
    int          hs_count [2];
    logic [31:0] obs_data [2];
    logic [31:0] got0 [$];
    logic [31:0] got1 [$];
    longint      acc1 [$];

    initial begin
        lat[0] = LAT0;
        lat[1] = LAT1;
        for (int p = 0; p < 2; p++) begin
            busy[p] = 1'b0; since[p] = 0; beats[p] = 0; base[p] = '0;
            hs_count[p] = 0; obs_data[p] = '0; req_addr[p] = 32'h0;
        end
    end

    function automatic bit exp_valid(int p);
        return busy[p] && (since[p] >= lat[p]);
    endfunction

    function automatic logic [31:0] exp_word(int p);
        int idx;
        idx = (int'(base[p]) * 8 + beats[p]) % MEM;
        return model_ram[idx];
    endfunction

    task automatic chk(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    endtask

    always @(posedge clk) begin
        if (preload_wen) model_ram[preload_addr[13:2]] = preload_wdata;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                busy[p] = 1'b0; since[p] = 0; beats[p] = 0;
            end
        end else begin
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (!busy[p]) begin
                    if (req_valid[p]) begin
                        busy[p]  = 1'b1;
                        base[p]  = req_addr[p][31:5];
                        since[p] = 0;
                        beats[p] = 0;
                        if (p == 1) acc1.push_back(cyc);
                    end
                end else begin
                    if (exp_valid(p) && rsp_ready[p]) begin
                        if (p == 0) got0.push_back(obs_data[0]);
                        else        got1.push_back(obs_data[1]);
                        hs_count[p]++;
                        if (beats[p] == 7) busy[p] = 1'b0;
                        else               beats[p]++;
                    end
                    since[p]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            obs_data[p] = rsp_data[p];
            if (rst) begin
                chk($sformatf("p%0d_rst_req_ready", p), 32'(req_ready[p]), 32'h0);
                chk($sformatf("p%0d_rst_rsp_valid", p), 32'(rsp_valid[p]), 32'h0);
            end else begin
                chk($sformatf("p%0d_req_ready", p), 32'(req_ready[p]), 32'(!busy[p]));
                chk($sformatf("p%0d_rsp_valid", p), 32'(rsp_valid[p]), 32'(exp_valid(p)));
                chk($sformatf("p%0d_rsp_last", p), 32'(rsp_last[p]),
                    32'(exp_valid(p) && beats[p] == 7));
                chk($sformatf("p%0d_rsp_data", p), rsp_data[p],
                    exp_valid(p) ? exp_word(p) : 32'h0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literals
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(int idx, logic [31:0] data);
        preload_wen   = 1'b1;
        preload_addr  = 32'(idx) << 2;
        preload_wdata = data;
        tick();
        preload_wen   = 1'b0;
    endtask

    task automatic request(int p, logic [31:0] a);
        bit ok;
        ok = 1'b0;
        req_valid[p] = 1'b1;
        req_addr[p]  = a;
        for (int n = 0; n < 300; n++) begin
            if (req_ready[p]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk($sformatf("p%0d_req_accept_timeout", p), 32'(ok), 32'h1);
        tick();
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_hs(int p, int target);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (hs_count[p] >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk($sformatf("p%0d_beat_timeout", p), 32'(ok), 32'h1);
    endtask

    task automatic check_line(string tag, int p, logic [31:0] first);
        int sz;
        sz = (p == 0) ? got0.size() : got1.size();
        chk({tag, "_beat_count"}, 32'(sz), 32'd8);
        for (int i = 0; i < sz && i < 8; i++) begin
            chk($sformatf("%s_beat%0d", tag, i), (p == 0) ? got0[i] : got1[i], first + 32'(i));
        end
    endtask

    task automatic first_beat_delay(string tag, int p, int expected);
        int k;
        k = 0;
        while (!rsp_valid[p] && k < 50) begin
            tick();
            k++;
        end
        chk(tag, 32'(k), 32'(expected));
    endtask

    initial begin
        int h0;
        #12;
        chk("reset_req_ready", 32'(req_ready[0]), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'h0);
        chk("reset_rsp_last",  32'(rsp_last[0]),  32'h0);
        chk("reset_rsp_data",  rsp_data[0],       32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_req_ready", 32'(req_ready), 32'h3);

        for (int i = 0; i < 8; i++) preload(32'h40 + i, 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 8; i++) preload(i, 32'h2000_0000 + 32'(i));

        // Single refill, latency 2, no backpressure
        rsp_ready[0] = 1'b1;
        got0.delete();
        h0 = hs_count[0];
        request(0, 32'h0000_0100);
        first_beat_delay("t1_first_beat_delay", 0, 2);
        wait_hs(0, h0 + 8);
        chk("t1_req_ready_after_last", 32'(req_ready[0]), 32'h1);
        check_line("t1", 0, 32'h1000_0000);

        // Backpressure pattern 1,0,0 repeating
        got0.delete();
        h0 = hs_count[0];
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0100;
        rsp_ready[0] = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        for (int i = 0; i < 200 && hs_count[0] < h0 + 8; i++) begin
            rsp_ready[0] = (i % 3 == 0);
            tick();
        end
        rsp_ready[0] = 1'b0;
        tick();
        tick();
        chk("t2_handshakes", 32'(hs_count[0] - h0), 32'd8);
        check_line("t2", 0, 32'h1000_0000);

        // Unaligned, aliasing address
        rsp_ready[0] = 1'b1;
        got0.delete();
        h0 = hs_count[0];
        request(0, 32'h0010_011C);
        wait_hs(0, h0 + 8);
        check_line("t3", 0, 32'h1000_0000);

        // Latency 0 with a second request held pending during the burst
        rsp_ready[1] = 1'b1;
        got1.delete();
        acc1.delete();
        request(1, 32'h0000_0000);
        first_beat_delay("t4_first_beat_delay", 1, 0);
        request(1, 32'h0000_0100);
        wait_hs(1, 16);
        chk("t4_accepts", 32'(acc1.size()), 32'd2);
        if (acc1.size() == 2) chk("t4_accept_spacing", 32'(acc1[1] - acc1[0]), 32'd9);
        chk("t4_beat0", got1.size() > 0 ? got1[0] : 32'hx, 32'h2000_0000);
        chk("t4_beat7", got1.size() > 7 ? got1[7] : 32'hx, 32'h2000_0007);
        chk("t4_second_beat0", got1.size() > 8 ? got1[8] : 32'hx, 32'h1000_0000);
        chk("t4_second_beat7", got1.size() > 15 ? got1[15] : 32'hx, 32'h1000_0007);

        // Asynchronous reset after beat 3's handshake
        h0 = hs_count[0];
        request(0, 32'h0000_0100);
        wait_hs(0, h0 + 4);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_rsp_valid", 32'(rsp_valid[0]), 32'h0);
        chk("t5_async_rsp_data",  rsp_data[0],       32'h0);
        chk("t5_async_req_ready", 32'(req_ready[0]), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t5_req_ready_after_release", 32'(req_ready[0]), 32'h1);
        got0.delete();
        h0 = hs_count[0];
        request(0, 32'h0000_0100);
        wait_hs(0, h0 + 8);
        check_line("t5", 0, 32'h1000_0000);

        // Preload writes during a burst
        got0.delete();
        h0 = hs_count[0];
        request(0, 32'h0000_0100);
        wait_hs(0, h0 + 2);
        preload_wen   = 1'b1;
        preload_addr  = 32'h45 << 2;
        preload_wdata = 32'hDEAD_BEEF;
        tick();
        preload_addr  = 32'h41 << 2;
        preload_wdata = 32'h5555_5555;
        tick();
        preload_wen   = 1'b0;
        wait_hs(0, h0 + 8);
        chk("t6_beat5_new", got0.size() > 5 ? got0[5] : 32'hx, 32'hDEAD_BEEF);
        chk("t6_beat1_old", got0.size() > 1 ? got0[1] : 32'hx, 32'h1000_0001);
        chk("t6_beat4_old", got0.size() > 4 ? got0[4] : 32'hx, 32'h1000_0004);

        tick();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/icache_burst_mem_responder.md
# icache_burst_mem_responder

Memory-side responder for the I-cache refill interface. It accepts one 32-byte-aligned read request at a time and returns the line as an 8-beat, 32-bit burst with a `last` flag, honouring backpressure on every beat. It is backed by a word-addressed instruction RAM with a side-band preload port. It sits between `icache_top`'s memory port and the testbench/SoC, replacing the AXI bridge in unit benches and small FPGA builds.

## Interface
- `MEM_WORDS`, default 4096: RAM depth in 32-bit words; power of two, at least 8.
- `RSP_LATENCY`, default 2: idle cycles between request acceptance and the first response beat, range 0..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `from_cache_rd_req_valid`  in  1  refill request valid.
- `from_cache_rd_req_addr`  in  32  refill byte address; bits [4:0] are ignored.
- `to_cache_rd_req_ready`  out  1  responder can accept a request.
- `to_cache_rd_rsp_valid`  out  1  current beat valid.
- `to_cache_rd_rsp_data`  out  32  current beat data.
- `to_cache_rd_rsp_last`  out  1  current beat is beat 7.
- `from_cache_rd_rsp_ready`  in  1  cache accepts the current beat.
- `preload_wen`  in  1  RAM write strobe, full word.
- `preload_addr`  in  32  RAM write byte address; bits [1:0] are ignored.
- `preload_wdata`  in  32  RAM write data.

## Operation
- States are one-hot: IDLE, LAT, BURST.
- **IDLE**
  - `req_ready` is 1.
  - On `req_valid && req_ready`, latch `line_base = addr[31:5]`, clear the beat counter and load the latency counter with `RSP_LATENCY`.
  - Go to LAT, or directly to BURST when `RSP_LATENCY == 0`.
- **LAT**
  - Decrement the counter each cycle.
  - When it reaches 1, go to BURST. The first beat appears exactly `RSP_LATENCY` cycles after the accept edge.
- **BURST**
  - `rsp_valid` is 1.
  - `rsp_data = ram[{line_base, beat} mod MEM_WORDS]`.
  - `rsp_last = (beat == 7)`.
  - On `rsp_valid && rsp_ready`, increment `beat` (3 bits).
  - The handshake on beat 7 returns the block to IDLE.
- While `rsp_ready` is low, `valid`, `data`, `last` and `beat` hold stable.
- `req_ready` is 0 in LAT and BURST; requests presented then are not accepted and remain pending at the source.
- Address wrap: word index = `{addr[31:5], beat}` truncated to log2(`MEM_WORDS`) bits. Out-of-range addresses alias; they never return an error.
- Preload
  - Writes `ram[preload_addr[..:2]]` on the edge where `preload_wen` is 1, in any state.
  - A write to a word of the active line that has not yet been sent is visible in that beat (read-after-write through the array).
  - A write to an already-sent beat has no effect on the burst.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `req_ready = 0` while `rst` is asserted, 1 on the first cycle after deassertion (state IDLE). `rsp_valid = 0`, `rsp_last = 0`, `rsp_data = 32'h0`.
- Reset mid-burst or mid-LAT: outputs drop to their reset values asynchronously. The partial burst is abandoned and never resumed.
- Minimum line time with `rsp_ready` held at 1: 1 accept cycle + `RSP_LATENCY` + 8 beats. The next request can be accepted on the cycle after the last beat's handshake; there are no back-to-back overlapping bursts.
- `rsp_data` outside BURST is 32'h0.
- The accept edge and a preload write in the same cycle are independent.

## Structure
- A shared package holds:
  - `LINE_BEATS` = 8
  - `LINE_OFFSET_WIDTH` = 5
  - `BEAT_WIDTH` = 3
  - the one-hot state encodings
- The package is reused by the I-cache and any future D-cache responder.
- One sub-module, `burst_word_ram`: parameterised depth, one synchronous write port, one asynchronous read port, no reset.
- The FSM, counters and handshake stay in the top module.

## Test plan
- **Preload and single refill, no backpressure, `RSP_LATENCY` = 2:**
  - Stimulus: `ram[0x40..0x47]` (word indices) = 0x1000_0000+i; request at addr 0x0000_0100.
  - Required: 8 beats 0x1000_0000..0x1000_0007 starting 2 cycles after accept; `last` only on beat 7; `req_ready` returns to 1 the next cycle.
- **Backpressure:**
  - Stimulus: same setup; `rsp_ready` toggles 1,0,0,1,...
  - Required: each beat's data and `last` held stable through its stalls; exactly 8 handshakes; data order unchanged.
- **Unaligned and aliasing address:**
  - Stimulus: request at addr 0x0010_011C with `MEM_WORDS` = 4096.
  - Required: returns the same line as 0x0000_0100 (low 5 bits ignored, upper bits aliased).
- **`RSP_LATENCY` = 0, plus a request while busy:**
  - Stimulus: request at 0x0000_0000 with latency 0; a second request presented during the burst.
  - Required: first beat valid on the cycle after accept; second request accepted only after beat 7's handshake.
- **Async reset mid-burst:**
  - Stimulus: assert `rst` after beat 3's handshake.
  - Required: `rsp_valid` goes to 0 immediately; after release, `req_ready` = 1; a new request to 0x0000_0100 starts again from beat 0.
- **Preload during burst:**
  - Stimulus: during beat 2, write word index 0x45 = 0xDEAD_BEEF.
  - Required: beat 5 returns 0xDEAD_BEEF; a later write to index 0x41 leaves the already-sent beat 1 unaffected.
